// File: rtl/irq_pkg.sv
// irq_pkg: shared constants, state encoding and helpers for the IRQ priority sequencer
package irq_pkg;
    localparam int N_BANK = 3;
    localparam int N_CHAN = 9;
    localparam int CHAN_W = 4;
    localparam logic [N_BANK-1:0] BANK_A = 3'b001;
    localparam logic [N_BANK-1:0] BANK_B = 3'b010;
    localparam logic [N_BANK-1:0] BANK_C = 3'b100;
    typedef enum logic [1:0] {IDLE, RESOLVE, ISSUE, CLEAR} state_t;
    function automatic logic [CHAN_W-1:0] lowest(input logic [N_CHAN-1:0] v);
        lowest = '0;
        for (int i = N_CHAN - 1; i >= 0; i--) if (v[i]) lowest = CHAN_W'(i);
    endfunction
endpackage

// File: rtl/irq_prio_resolve.sv
// irq_prio_resolve: combinational 27-channel winner select, A>B>C unless promotion favours the lowest eligible bank
module irq_prio_resolve
    import irq_pkg::*;
(
    input  logic [N_CHAN-1:0] elig_a,
    input  logic [N_CHAN-1:0] elig_b,
    input  logic [N_CHAN-1:0] elig_c,
    input  logic              promote,
    output logic              any,
    output logic [N_BANK-1:0] win_bank,
    output logic [CHAN_W-1:0] win_chan
);
    logic [N_CHAN-1:0] sel;
    always_comb begin
        any      = |{elig_a, elig_b, elig_c};
        win_bank = promote && |elig_c ? BANK_C :
                   promote && |elig_b ? BANK_B :
                   |elig_a ? BANK_A : |elig_b ? BANK_B : |elig_c ? BANK_C : '0;
        sel      = win_bank == BANK_A ? elig_a : win_bank == BANK_B ? elig_b : elig_c;
        win_chan = lowest(sel);
    end
endmodule

// File: rtl/irq_prio_sequencer.sv
// irq_prio_sequencer: edge-captured sticky IRQ pending bits, one-at-a-time valid/ack grants with starvation promotion
module irq_prio_sequencer
    import irq_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CHAN-1:0] req_a,
    input  logic [N_CHAN-1:0] req_b,
    input  logic [N_CHAN-1:0] req_c,
    input  logic [N_CHAN-1:0] chan_en,
    output logic              irq_valid,
    input  logic              irq_ack,
    output logic [N_BANK-1:0] irq_bank,
    output logic [CHAN_W-1:0] irq_chan,
    output logic              busy
);
    state_t state, state_n;
    logic [N_CHAN-1:0] pend_a, pend_b, pend_c, rq_a, rq_b, rq_c;
    logic [N_CHAN-1:0] elig_a, elig_b, elig_c, clr;
    logic [N_BANK-1:0] res_bank, win_bank, bank_n;
    logic [CHAN_W-1:0] res_chan, win_chan, chan_n;
    logic [7:0] starve_cnt;
    logic any, promote, lower;

    irq_prio_resolve u_resolve (
        .elig_a  (elig_a),
        .elig_b  (elig_b),
        .elig_c  (elig_c),
        .promote (promote),
        .any     (any),
        .win_bank(res_bank),
        .win_chan(res_chan)
    );

    always_comb begin
        elig_a  = pend_a & chan_en;
        elig_b  = pend_b & chan_en;
        elig_c  = pend_c & chan_en;
        promote = STARVE_LIMIT != 0 && starve_cnt == 8'(STARVE_LIMIT) && |{elig_b, elig_c};
        lower   = res_bank == BANK_A ? |{elig_b, elig_c} : res_bank == BANK_B ? |elig_c : 1'b0;
        state_n = state == IDLE    ? (any ? RESOLVE : IDLE) :
                  state == RESOLVE ? (any ? ISSUE : IDLE) :
                  state == ISSUE   ? (irq_ack ? CLEAR : ISSUE) : IDLE;
        bank_n  = state == RESOLVE ? res_bank : win_bank;
        chan_n  = state == RESOLVE ? res_chan : win_chan;
        clr     = state == CLEAR ? N_CHAN'(1) << win_chan : '0;
    end

    // Set is OR-ed after the clear so a re-rising request survives its own CLEAR edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pend_a     <= '0;
            pend_b     <= '0;
            pend_c     <= '0;
            rq_a       <= '0;
            rq_b       <= '0;
            rq_c       <= '0;
            starve_cnt <= '0;
            win_bank   <= '0;
            win_chan   <= '0;
            irq_valid  <= 1'b0;
            irq_bank   <= '0;
            irq_chan   <= '0;
            busy       <= 1'b0;
        end else begin
            state     <= state_n;
            rq_a      <= req_a;
            rq_b      <= req_b;
            rq_c      <= req_c;
            pend_a    <= (pend_a & ~(win_bank[0] ? clr : '0)) | (req_a & ~rq_a);
            pend_b    <= (pend_b & ~(win_bank[1] ? clr : '0)) | (req_b & ~rq_b);
            pend_c    <= (pend_c & ~(win_bank[2] ? clr : '0)) | (req_c & ~rq_c);
            irq_valid <= state_n == ISSUE;
            irq_bank  <= state_n == ISSUE ? bank_n : '0;
            irq_chan  <= state_n == ISSUE ? chan_n : '0;
            busy      <= state_n != IDLE;
            if (state == RESOLVE && any) begin
                win_bank   <= res_bank;
                win_chan   <= res_chan;
                starve_cnt <= promote || !lower ? '0 :
                              starve_cnt == 8'(STARVE_LIMIT) ? starve_cnt : starve_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_irq_prio_sequencer.sv
// tb_irq_prio_sequencer: table vectors, directed handshake/starvation/reset sequences, and random traffic vs a grant-level model
module tb_irq_prio_sequencer;
    import irq_pkg::*;

    logic clk = 1'b0, rst = 1'b1, irq_ack = 1'b0;
    logic [8:0] req_a = '0, req_b = '0, req_c = '0, chan_en = 9'h1FF;
    logic irq_valid, busy;
    logic [2:0] irq_bank;
    logic [3:0] irq_chan;

    irq_prio_sequencer #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .chan_en(chan_en), .irq_valid(irq_valid), .irq_ack(irq_ack),
        .irq_bank(irq_bank), .irq_chan(irq_chan), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    bit [8:0] m_pend[3], m_rq[3];
    int m_cnt = 0;

    typedef struct {
        logic [8:0] a, b, c, en;
        int bank, chan;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit [8:0] reqv(input int b);
        return b == 0 ? req_a : b == 1 ? req_b : req_c;
    endfunction

    task automatic step();
        @(posedge clk);
        for (int b = 0; b < 3; b++) begin
            m_pend[b] = rst ? 9'h0 : m_pend[b] | (reqv(b) & ~m_rq[b]);
            m_rq[b]   = rst ? 9'h0 : reqv(b);
        end
        if (rst) m_cnt = 0;
        #1;
    endtask

    task automatic wait_grant(input int max, output int n);
        n = 0;
        while (!irq_valid && n < max) begin
            step();
            n++;
        end
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_a = '0; req_b = '0; req_c = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic expect_grant(input string name, input int bank, input int chan, input int max);
        int n;
        wait_grant(max, n);
        chk({name, "_valid"}, int'(irq_valid), 1);
        chk({name, "_bank"}, int'(irq_bank), bank);
        chk({name, "_chan"}, int'(irq_chan), chan);
    endtask

    // Grant decision made from the pending/enable picture and the run of starved grants
    task automatic predict(output int wb, output int wc);
        bit [8:0] e[3];
        bit low;
        for (int b = 0; b < 3; b++) e[b] = m_pend[b] & chan_en;
        if (m_cnt == 4 && (e[1] | e[2]) != 0) begin
            wb = e[2] != 0 ? 2 : 1;
            m_cnt = 0;
        end else begin
            wb = e[0] != 0 ? 0 : e[1] != 0 ? 1 : 2;
            low = 0;
            for (int k = wb + 1; k < 3; k++) if (e[k] != 0) low = 1;
            m_cnt = low ? (m_cnt < 4 ? m_cnt + 1 : 4) : 0;
        end
        wc = 0;
        for (int i = 8; i >= 0; i--) if (e[wb][i]) wc = i;
    endtask

    initial begin
        vec_t vecs[6];
        int n, gb, gc, grants;
        bit was_valid;
        vecs[0] = '{9'h000, 9'h000, 9'h100, 9'h1FF, 4, 8};
        vecs[1] = '{9'h180, 9'h001, 9'h001, 9'h1FF, 1, 7};
        vecs[2] = '{9'h180, 9'h000, 9'h000, 9'h17F, 1, 8};
        vecs[3] = '{9'h001, 9'h010, 9'h000, 9'h1FE, 2, 4};
        vecs[4] = '{9'h000, 9'h006, 9'h003, 9'h1F9, 4, 0};
        vecs[5] = '{9'h1FF, 9'h000, 9'h000, 9'h100, 1, 8};

        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_outputs", int'({irq_valid, irq_bank, irq_chan, busy}), 0);
        end

        req_b[5] = 1'b1;
        wait_grant(8, n);
        chk("latency", n, 3);
        chk("lat_bank", int'(irq_bank), 2);
        chk("lat_chan", int'(irq_chan), 5);
        chk("lat_busy", int'(busy), 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_stable", int'({irq_valid, irq_bank, irq_chan}), int'({1'b1, 3'b010, 4'd5}));
        end
        ack();
        chk("ack_drop", int'({irq_valid, irq_bank, irq_chan}), 0);
        chk("clear_busy", int'(busy), 1);
        wait_grant(10, n);
        chk("b5_cleared", int'(irq_valid), 0);
        chk("idle_busy", int'(busy), 0);
        req_b = '0;

        req_a[7] = 1'b1; req_b[0] = 1'b1; req_c[0] = 1'b1;
        expect_grant("prio1", 1, 7, 8);
        ack();
        wait_grant(8, n);
        chk("g2g_period", n, 3);
        chk("prio2_bank", int'(irq_bank), 2);
        chk("prio2_chan", int'(irq_chan), 0);
        ack();
        expect_grant("prio3", 4, 0, 8);
        ack();
        req_a = '0; req_b = '0; req_c = '0;

        chan_en = 9'h1FB;
        req_a[2] = 1'b1;
        wait_grant(20, n);
        chk("masked_no_grant", int'(irq_valid), 0);
        chan_en = 9'h1FF;
        expect_grant("unmask", 1, 2, 6);
        ack();

        foreach (vecs[i]) begin
            do_reset();
            req_a = vecs[i].a; req_b = vecs[i].b; req_c = vecs[i].c; chan_en = vecs[i].en;
            expect_grant($sformatf("vec%0d", i), vecs[i].bank, vecs[i].chan, 8);
            ack();
        end
        chan_en = 9'h1FF;

        do_reset();
        req_a = 9'h03F; req_c[3] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            expect_grant($sformatf("starve%0d", i), i == 4 ? 4 : 1, i == 4 ? 3 : (i < 4 ? i : i - 1), 8);
            ack();
        end

        do_reset();
        req_a[1] = 1'b1;
        expect_grant("svc_first", 1, 1, 8);
        irq_ack = 1'b1; req_a = '0;
        step();
        irq_ack = 1'b0; req_a[1] = 1'b1;
        step();
        expect_grant("svc_second", 1, 1, 6);
        ack();
        req_a = '0;
        wait_grant(8, n);
        chk("svc_done", int'(irq_valid), 0);

        req_c[8] = 1'b1;
        expect_grant("rst_pre", 4, 8, 8);
        do_reset();
        chk("rst_valid", int'({irq_valid, irq_bank, irq_chan, busy}), 0);
        wait_grant(10, n);
        chk("rst_no_grant", int'(irq_valid), 0);

        do_reset();
        chan_en = 9'h1FF;
        grants = 0; was_valid = 0; gb = 0; gc = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bit quiet, acking;
            quiet = 1;
            for (int b = 0; b < 3; b++) if ((m_pend[b] & chan_en) != 0) quiet = 0;
            acking = 0;
            if (irq_valid || quiet) begin
                if ($urandom_range(0, 2) == 0) begin
                    req_a = 9'($urandom & $urandom & $urandom);
                    req_b = 9'($urandom & $urandom);
                    req_c = 9'($urandom & $urandom);
                end
                if ($urandom_range(0, 3) == 0) chan_en = 9'($urandom | $urandom);
            end
            if (irq_valid) acking = $urandom_range(0, 2) == 0;
            else irq_ack = $urandom_range(0, 7) == 0;
            if (acking) irq_ack = 1'b1;
            was_valid = irq_valid;
            step();
            irq_ack = 1'b0;
            if (acking) m_pend[gb][gc] = 1'b0;
            if (irq_valid && !was_valid) begin
                predict(gb, gc);
                grants++;
                chk("rnd_bank", int'(irq_bank), 1 << gb);
                chk("rnd_chan", int'(irq_chan), gc);
            end else if (irq_valid && acking) begin
                chk("rnd_ack_drop", int'(irq_valid), 0);
            end
        end
        chk("rnd_had_grants", int'(grants > 20), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
